// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for a small core: gates core advance with a budget,
// a single-address breakpoint and a host command channel.
module cpu_run_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   input  logic [3:0]       pc_in,
   output logic             core_en,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      ST_HALTED,
      ST_RUN,
      ST_STEP
   } state_t;

   localparam logic [1:0] OP_RUN    = 2'b00;
   localparam logic [1:0] OP_STEP   = 2'b01;
   localparam logic [1:0] OP_HALT   = 2'b10;
   localparam logic [1:0] OP_SET_BP = 2'b11;

   localparam logic [1:0] CAUSE_RESET = 2'b00;
   localparam logic [1:0] CAUSE_HALT  = 2'b01;
   localparam logic [1:0] CAUSE_BP    = 2'b10;
   localparam logic [1:0] CAUSE_DONE  = 2'b11;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   budget_q, budget_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               first_q, first_d;
   logic               bp_en_q, bp_en_d;
   logic [3:0]         bp_addr_q, bp_addr_d;
   logic [1:0]         cause_q, cause_d;
   logic               accept;
   logic               bp_hit;

   always_comb begin
      state_d   = state_q;
      budget_d  = budget_q;
      retired_d = retired_q;
      first_d   = first_q;
      bp_en_d   = bp_en_q;
      bp_addr_d = bp_addr_q;
      cause_d   = cause_q;

      cmd_ready = (state_q != ST_STEP);
      accept    = cmd_valid && cmd_ready;
      // The first RUN cycle never hits, so a resume from a breakpoint moves past it.
      bp_hit    = (state_q == ST_RUN) && bp_en_q && (pc_in == bp_addr_q) && !first_q;
      core_en   = reset && ((state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_hit));

      if (core_en && (retired_q != '1)) begin
         retired_d = retired_q + CNT_W'(1);
      end

      if (accept && (cmd_op == OP_SET_BP)) begin
         bp_addr_d = cmd_arg[3:0];
         bp_en_d   = cmd_arg[4];
      end

      case (state_q)
         ST_HALTED: begin
            if (accept && (cmd_op == OP_RUN)) begin
               state_d   = ST_RUN;
               budget_d  = cmd_arg;
               retired_d = '0;
               first_d   = 1'b1;
            end else if (accept && (cmd_op == OP_STEP)) begin
               state_d   = ST_STEP;
               retired_d = '0;
            end
         end
         ST_RUN: begin
            first_d = 1'b0;
            // Stop causes are checked in priority order: breakpoint, budget, HALT.
            if (bp_hit) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_BP;
            end else begin
               if (budget_q != '0) begin
                  budget_d = budget_q - CNT_W'(1);
               end
               if (budget_q == CNT_W'(1)) begin
                  state_d = ST_HALTED;
                  cause_d = CAUSE_DONE;
               end else if (accept && (cmd_op == OP_HALT)) begin
                  state_d = ST_HALTED;
                  cause_d = CAUSE_HALT;
               end
            end
         end
         ST_STEP: begin
            state_d = ST_HALTED;
            cause_d = CAUSE_DONE;
         end
         default: begin
            state_d = ST_HALTED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_HALTED;
         budget_q  <= '0;
         retired_q <= '0;
         first_q   <= 1'b0;
         bp_en_q   <= 1'b0;
         bp_addr_q <= '0;
         cause_q   <= CAUSE_RESET;
      end else begin
         state_q   <= state_d;
         budget_q  <= budget_d;
         retired_q <= retired_d;
         first_q   <= first_d;
         bp_en_q   <= bp_en_d;
         bp_addr_q <= bp_addr_d;
         cause_q   <= cause_d;
      end
   end

   assign halted     = (state_q == ST_HALTED);
   assign halt_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed vector bench for cpu_run_ctrl: each row is one clock cycle, outputs
// checked just after the inputs settle, before the rising edge.
module tb_cpu_run_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_arg;
   logic [3:0] pc_in;
   logic       core_en;
   logic       halted;
   logic [1:0] halt_cause;
   logic [7:0] retired;

   int unsigned checks = 0;
   int unsigned errors = 0;

   cpu_run_ctrl #(.CNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_arg    (cmd_arg),
      .pc_in      (pc_in),
      .core_en    (core_en),
      .halted     (halted),
      .halt_cause (halt_cause),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       v;
      logic [1:0] op;
      logic [7:0] arg;
      logic [3:0] pc;
      logic       ce;
      logic       rdy;
      logic       h;
      logic [1:0] c;
      logic [7:0] r;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic v, input logic [1:0] op, input logic [7:0] arg,
                      input logic [3:0] pc, input logic ce, input logic rdy, input logic h,
                      input logic [1:0] c, input logic [7:0] r);
      vec_t e;
      e.rst = rst; e.v = v; e.op = op; e.arg = arg; e.pc = pc;
      e.ce = ce; e.rdy = rdy; e.h = h; e.c = c; e.r = r;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic v, input logic [1:0] op,
                        input logic [7:0] arg, input logic [3:0] pc);
      @(negedge clk);
      reset = rst; cmd_valid = v; cmd_op = op; cmd_arg = arg; pc_in = pc;
      #1;
   endtask

   initial begin
      int n;
      int cnt;
      bit done;

      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0; pc_in = '0;
      repeat (2) @(posedge clk);

      // reset; a command offered under reset is dropped
      add(0,1,0,8'd5,0, 0,1,1,0,0);
      add(1,0,0,0,0,    0,1,1,0,0);
      // RUN budget 5
      add(1,1,0,8'd5,0, 0,1,1,0,0);
      for (int i = 0; i < 5; i++) add(1,0,0,0,0, 1,1,0,0,8'(i));
      add(1,0,0,0,0,    0,1,1,3,5);
      // RUN unlimited, HALT after 4 cycles, then HALT while halted
      add(1,1,0,0,8,    0,1,1,3,5);
      for (int i = 0; i < 4; i++) add(1,0,0,0,4'(8+i), 1,1,0,3,8'(i));
      add(1,1,2,0,12,   1,1,0,3,4);
      add(1,1,2,0,12,   0,1,1,1,5);
      add(1,0,0,0,12,   0,1,1,1,5);
      // STEP; a HALT held during STEP waits, then is a no-op in HALTED
      add(1,1,1,0,8,    0,1,1,1,5);
      add(1,1,2,0,8,    1,0,0,1,0);
      add(1,1,2,0,8,    0,1,1,3,1);
      add(1,0,0,0,8,    0,1,1,3,1);
      // breakpoint at 3, RUN unlimited
      add(1,1,3,8'h13,0, 0,1,1,3,1);
      add(1,1,0,0,0,    0,1,1,3,1);
      add(1,0,0,0,0,    1,1,0,3,0);
      add(1,0,0,0,1,    1,1,0,3,1);
      add(1,0,0,0,2,    1,1,0,3,2);
      add(1,0,0,0,3,    0,1,0,3,3);
      add(1,0,0,0,3,    0,1,1,2,3);
      // resume from the breakpoint; a RUN while running is ignored
      add(1,1,0,0,3,    0,1,1,2,3);
      add(1,0,0,0,3,    1,1,0,2,0);
      add(1,1,0,8'd2,4, 1,1,0,2,1);
      add(1,0,0,0,5,    1,1,0,2,2);
      add(1,0,0,0,6,    1,1,0,2,3);
      add(1,1,2,0,7,    1,1,0,2,4);
      add(1,0,0,0,7,    0,1,1,1,5);
      // breakpoint and budget expiry in the same cycle
      add(1,1,0,8'd3,0, 0,1,1,1,5);
      add(1,0,0,0,0,    1,1,0,1,0);
      add(1,0,0,0,1,    1,1,0,1,1);
      add(1,0,0,0,3,    0,1,0,1,2);
      add(1,0,0,0,3,    0,1,1,2,2);
      // reset mid-RUN clears breakpoint, cause and retired
      add(1,1,0,0,3,    0,1,1,2,2);
      add(1,0,0,0,4,    1,1,0,2,0);
      add(1,0,0,0,5,    1,1,0,2,1);
      add(0,0,0,0,6,    0,1,0,2,2);
      add(1,0,0,0,3,    0,1,1,0,0);
      add(1,1,0,0,3,    0,1,1,0,0);
      add(1,0,0,0,3,    1,1,0,0,0);
      add(1,0,0,0,3,    1,1,0,0,1);
      add(0,0,0,0,3,    0,1,0,0,2);
      add(1,0,0,0,3,    0,1,1,0,0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].op, tbl[i].arg, tbl[i].pc);
         chk($sformatf("row%0d core_en", i),    int'(core_en),    int'(tbl[i].ce));
         chk($sformatf("row%0d cmd_ready", i),  int'(cmd_ready),  int'(tbl[i].rdy));
         chk($sformatf("row%0d halted", i),     int'(halted),     int'(tbl[i].h));
         chk($sformatf("row%0d halt_cause", i), int'(halt_cause), int'(tbl[i].c));
         chk($sformatf("row%0d retired", i),    int'(retired),    int'(tbl[i].r));
      end

      // reset during STEP: core_en drops at once, HALTED after the edge
      drive(1,1,1,0,0);
      drive(0,0,0,0,0);
      chk("step_rst core_en", int'(core_en), 0);
      chk("step_rst cmd_ready", int'(cmd_ready), 0);
      drive(1,0,0,0,0);
      chk("step_rst halted", int'(halted), 1);
      chk("step_rst cause", int'(halt_cause), 0);
      chk("step_rst retired", int'(retired), 0);

      // RUN budget 5 counted with a bounded wait for halted
      drive(1,1,0,8'd5,0);
      cnt = 0; done = 0; n = 0;
      while (!done && n < 20) begin
         drive(1,0,0,0,0);
         if (halted) done = 1;
         else if (core_en) cnt++;
         n++;
      end
      chk("budget5 timeout", int'(done), 1);
      chk("budget5 core_en cycles", cnt, 5);
      chk("budget5 cause", int'(halt_cause), 3);
      chk("budget5 retired", int'(retired), 5);

      // retired saturates at all-ones
      drive(1,1,0,0,8);
      repeat (300) drive(1,0,0,0,8);
      chk("sat retired", int'(retired), 255);
      chk("sat core_en", int'(core_en), 1);
      drive(1,1,2,0,8);
      drive(1,0,0,0,8);
      chk("sat halted", int'(halted), 1);
      chk("sat retired hold", int'(retired), 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Parameters
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the budget counter and the retired counter.

Interface
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at the clk edge.
REQ-006 SHALL have port cmd_op  input  2  command: 00 RUN, 01 STEP, 10 HALT, 11 SET_BP.
REQ-007 SHALL have port cmd_arg  input  CNT_W  RUN: instruction budget (0 = unlimited); SET_BP: [3:0] breakpoint address, [4] breakpoint enable.
REQ-008 SHALL have port pc_in  input  4  current core PC (pc_debug of the CPU).
REQ-009 SHALL have port core_en  output  1  core advance enable; the core retires exactly one instruction per cycle with core_en=1.
REQ-010 SHALL have port halted  output  1  controller in HALTED state.
REQ-011 SHALL have port halt_cause  output  2  00 reset, 01 HALT command, 10 breakpoint, 11 budget exhausted or step complete.
REQ-012 SHALL have port retired  output  CNT_W  core_en cycles since the last accepted RUN/STEP, saturating at all-ones.

Function
REQ-013 SHALL implement states HALTED, RUN and STEP; halted = (state==HALTED).
REQ-014 SHALL drive cmd_ready = 0 in STEP and cmd_ready = 1 otherwise; a cmd_valid held in STEP waits for acceptance.
REQ-015 SHALL, on RUN accepted in HALTED: state -> RUN; load budget from cmd_arg; clear retired; set the first-cycle flag.
REQ-016 SHALL, on STEP accepted in HALTED: state -> STEP; clear retired.
REQ-017 SHALL accept RUN and STEP while in RUN and ignore them (no state, budget or retired change).
REQ-018 SHALL, on SET_BP accepted in any state: load bp_addr=cmd_arg[3:0] and bp_en=cmd_arg[4], effective from the next cycle.
REQ-019 SHALL drive core_en combinationally: 1 in STEP; 1 in RUN unless a breakpoint hit; 0 in HALTED; 0 whenever reset=0.
REQ-020 SHALL define a breakpoint hit as state==RUN && bp_en && pc_in==bp_addr && first-cycle flag clear; the hit cycle has core_en=0, so the instruction at bp_addr is not executed.
REQ-021 SHALL clear the first-cycle flag after the first RUN cycle, so RUN resumes past a breakpoint.
REQ-022 SHALL, with a nonzero budget, decrement the budget on each core_en cycle in RUN; when it decrements from 1 to 0: state -> HALTED, cause 11; exactly B core_en cycles occur for budget B.
REQ-023 SHALL never expire a budget of 0 (unlimited).
REQ-024 SHALL, in STEP, assert core_en for exactly one cycle, then go HALTED with cause 11.
REQ-025 SHALL, on HALT accepted in RUN: go HALTED at that edge; core_en stays 1 in the acceptance cycle unless a breakpoint hits; cause 01.
REQ-026 SHALL treat HALT accepted in HALTED as a no-op; halt_cause is unchanged.
REQ-027 SHALL resolve simultaneous stop events in one cycle by cause priority: breakpoint (10) > budget (11) > HALT command (01).
REQ-028 SHALL increment retired on every core_en=1 cycle, saturating at 2^CNT_W-1.
REQ-029 SHALL hold halt_cause stable until the next transition into HALTED.

Reset
REQ-030 SHALL, at a clk edge with reset=0, set: state HALTED, halted=1, halt_cause=00, bp_en=0, bp_addr=0, budget=0, retired=0, first-cycle flag=0; a command presented in that cycle is dropped.
REQ-031 SHALL yield, after reset: core_en=0 and cmd_ready=1.
REQ-032 SHALL, on reset asserted mid-RUN or mid-STEP: core_en=0 in the same cycle, HALTED from the next edge.

Verification
REQ-033 SHALL cover: reset, then RUN with arg=5 -> core_en=1 for exactly 5 cycles, then halted=1, halt_cause=11, retired=5.
REQ-034 SHALL cover: SET_BP arg=0x13 (addr 3, enabled), RUN arg=0, PC counts 0,1,2,3 -> core_en=0 while pc_in=3, halted=1, cause=10, retired=3; a second RUN -> core_en=1 on the first cycle with pc_in=3.
REQ-035 SHALL cover: STEP from HALTED -> one core_en pulse, cmd_ready=0 for that cycle, halted=1, cause=11, retired=1.
REQ-036 SHALL cover: RUN arg=0, HALT after 4 cycles -> retired=5 (acceptance cycle included), cause=01; HALT again -> cause still 01.
REQ-037 SHALL cover: RUN arg=3 with a breakpoint hit in the same cycle the budget would expire -> cause=10, core_en=0 that cycle.
REQ-038 SHALL cover: reset=0 during RUN -> core_en=0 immediately; after the edge, halted=1, cause=00, bp_en=0, retired=0.
